// File: rtl/oil_slick_mover.sv
// Falling oil-slick obstacle: spawn/move/hit sequencing plus a registered pixel hit-test.
// Define OIL_RANDOM_SPAWN_EN to pick the spawn X from an LFSR instead of a fixed 4-lane rotation.
module oil_slick_mover #(
  parameter int          OBJECT_W    = 64,
  parameter int          OBJECT_H    = 32,
  parameter int          SCREEN_H    = 480,
  parameter int          LANE_MIN_X  = 160,
  parameter int          LANE_SPAN   = 256,
  parameter int          SPAWN_DELAY = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [3:0]  speed,
  input  logic        enable,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        active
);

  // state      | meaning
  // IDLE       | game stopped, object hidden
  // WAIT_SPAWN | counting frames before the next drop
  // MOVING     | falling down the screen, drawn and collidable
  // HIT        | struck by the player car, hidden for 16 frames
  typedef enum logic [1:0] {IDLE, WAIT_SPAWN, MOVING, HIT} state_t;

  localparam int DLY_W = (SPAWN_DELAY < 2) ? 1 : $clog2(SPAWN_DELAY + 1);
  localparam logic signed [11:0] START_Y  = 12'(-OBJECT_H);
  localparam logic signed [11:0] SCREEN_Y = 12'(SCREEN_H);

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if ((LANE_SPAN < 4) || ((LANE_SPAN & (LANE_SPAN - 1)) != 0)) begin : g_bad_span
    $error("LANE_SPAN must be a power of two, at least 4");
  end

  state_t             state, state_nx;
  logic [DLY_W-1:0]   delay_cnt, delay_cnt_nx;
  logic [3:0]         hit_cnt, hit_cnt_nx;
  logic [10:0]        top_left_x, top_left_x_nx;
  logic signed [11:0] top_left_y, top_left_y_nx;
  logic signed [11:0] y_step;
  logic [10:0]        spawn_x;
  logic               spawn;

`ifdef OIL_RANDOM_SPAWN_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [15:0] lane_off;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), free-running every clock.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Mask with LANE_SPAN-2 gives the modulo and the even-pixel rounding in one step.
  assign lane_off = lfsr & 16'(LANE_SPAN - 2);
  assign spawn_x  = 11'(LANE_MIN_X) + lane_off[10:0];
`else
  logic [1:0] spawn_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      spawn_idx <= 2'd0;
    else if (spawn) spawn_idx <= spawn_idx + 2'd1;
  end

  always_comb begin
    spawn_x = 11'(LANE_MIN_X);
    case (spawn_idx)
      2'd0: spawn_x = 11'(LANE_MIN_X);
      2'd1: spawn_x = 11'(LANE_MIN_X + LANE_SPAN / 4);
      2'd2: spawn_x = 11'(LANE_MIN_X + LANE_SPAN / 2);
      2'd3: spawn_x = 11'(LANE_MIN_X + (3 * LANE_SPAN) / 4);
      default: spawn_x = 11'(LANE_MIN_X);
    endcase
  end
`endif

  assign y_step = top_left_y + 12'(speed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      delay_cnt  <= '0;
      hit_cnt    <= '0;
      top_left_x <= 11'(LANE_MIN_X);
      top_left_y <= START_Y;
    end else begin
      state      <= state_nx;
      delay_cnt  <= delay_cnt_nx;
      hit_cnt    <= hit_cnt_nx;
      top_left_x <= top_left_x_nx;
      top_left_y <= top_left_y_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    delay_cnt_nx  = delay_cnt;
    hit_cnt_nx    = hit_cnt;
    top_left_x_nx = top_left_x;
    top_left_y_nx = top_left_y;
    spawn         = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx     = WAIT_SPAWN;
          delay_cnt_nx = DLY_W'(SPAWN_DELAY);
        end
        WAIT_SPAWN: begin
          if (startOfFrame) begin
            if (delay_cnt == '0) begin
              state_nx      = MOVING;
              top_left_x_nx = spawn_x;
              top_left_y_nx = START_Y;
              spawn         = 1'b1;
            end else begin
              delay_cnt_nx = delay_cnt - DLY_W'(1);
            end
          end
        end
        MOVING: begin
          // A hit wins over the frame step so the slick freezes where it was struck.
          if (collision) begin
            state_nx   = HIT;
            hit_cnt_nx = 4'd15;
          end else if (startOfFrame) begin
            top_left_y_nx = y_step;
            if (y_step >= SCREEN_Y) begin
              state_nx     = WAIT_SPAWN;
              delay_cnt_nx = DLY_W'(SPAWN_DELAY);
            end
          end
        end
        HIT: begin
          if (startOfFrame) begin
            if (hit_cnt == 4'd0) begin
              state_nx     = WAIT_SPAWN;
              delay_cnt_nx = DLY_W'(SPAWN_DELAY);
            end else begin
              hit_cnt_nx = hit_cnt - 4'd1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Pixel hit-test; Y is signed so rows above the screen clip without special casing.
  logic [11:0]        px_w, x_lo, x_hi;
  logic signed [11:0] py_s, y_hi;
  logic               in_x, in_y, inside_nx;

  assign px_w      = {1'b0, pixelX};
  assign x_lo      = {1'b0, top_left_x};
  assign x_hi      = x_lo + 12'(OBJECT_W);
  assign py_s      = {1'b0, pixelY};
  assign y_hi      = top_left_y + 12'(OBJECT_H);
  assign in_x      = (px_w >= x_lo) && (px_w < x_hi);
  assign in_y      = (py_s >= top_left_y) && (py_s < y_hi);
  assign inside_nx = (state == MOVING) && in_x && in_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= inside_nx;
      offsetX         <= inside_nx ? 11'(px_w - x_lo) : 11'd0;
      offsetY         <= inside_nx ? 11'(py_s - top_left_y) : 11'd0;
    end
  end

  assign active = (state == MOVING);

endmodule

// File: doc/oil_slick_mover.md
OIL_SLICK_MOVER -- requirements
Module: oil_slick_mover

Interface
REQ-001 SHALL have parameter OBJECT_W, default 64, meaning object width in pixels (32-column bitmap at 2x scale).
REQ-002 SHALL have parameter OBJECT_H, default 32, meaning object height in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 480, meaning the visible row count.
REQ-004 SHALL have parameter LANE_MIN_X, default 160, meaning the minimum spawn X.
REQ-005 SHALL have parameter LANE_SPAN, default 256 (power of two), meaning the spawn X range.
REQ-006 SHALL have parameter SPAWN_DELAY, default 60, meaning frames between exit and respawn.
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero random seed.
REQ-008 SHALL have port clk, input, 1 bit: the system clock.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port startOfFrame, input, 1 bit: a one-clk pulse per frame.
REQ-011 SHALL have ports pixelX and pixelY, input, 11 bits each: the current scan pixel.
REQ-012 SHALL have port speed, input, 4 bits: rows moved per frame.
REQ-013 SHALL have port enable, input, 1 bit: the game-running flag.
REQ-014 SHALL have port collision, input, 1 bit: a player-car hit on this object.
REQ-015 SHALL have ports offsetX and offsetY, output, 11 bits each: pixel offset from the object's top-left.
REQ-016 SHALL have port InsideRectangle, output, 1 bit: the pixel is inside the visible object.
REQ-017 SHALL have port active, output, 1 bit: high while in MOVING.

Function
REQ-018 SHALL implement the states IDLE, WAIT_SPAWN, MOVING and HIT.
REQ-019 SHALL, when enable=0, go to IDLE on the next clk from any state.
REQ-020 SHALL, in IDLE, go to WAIT_SPAWN when enable=1, loading delayCnt=SPAWN_DELAY.
REQ-021 SHALL, in WAIT_SPAWN, decrement delayCnt on each startOfFrame.
  - When delayCnt is 0 on a startOfFrame, the state becomes MOVING.
  - On that transition, topLeftY=-OBJECT_H (12-bit signed) and topLeftX=spawn X.
REQ-022 SHALL, in MOVING on startOfFrame, set topLeftY += speed.
  - speed=0 freezes the object.
  - If the new topLeftY >= SCREEN_H, the state becomes WAIT_SPAWN with delayCnt=SPAWN_DELAY.
REQ-023 SHALL, when collision=1 in MOVING, go to HIT with hitCnt=15 and freeze the position.
  - collision has priority over a simultaneous startOfFrame or exit.
REQ-024 SHALL, in HIT, decrement hitCnt per startOfFrame and go to WAIT_SPAWN after 0 (16 frames); collision is ignored in HIT.
REQ-025 SHALL register InsideRectangle, offsetX and offsetY with one clk latency from pixelX and pixelY.
REQ-026 SHALL set InsideRectangle=1 only when all of the following hold:
  - the state is MOVING;
  - topLeftX <= pixelX < topLeftX+OBJECT_W;
  - topLeftY <= pixelY < topLeftY+OBJECT_H, using signed 12-bit compare.
REQ-027 SHALL output offsetX=pixelX-topLeftX and offsetY=pixelY-topLeftY, truncated to 11 bits, when inside, and 0 otherwise.
REQ-028 SHALL clip partially above-screen rows naturally; no offsetY exceeds OBJECT_H-1 while InsideRectangle=1.
REQ-029 SHALL hold active=1 exactly in MOVING.
REQ-030 SHALL advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) every clk.

Reset
REQ-031 SHALL, on reset=1 (asynchronous), set the following values:
  - state=IDLE;
  - topLeftX=LANE_MIN_X, topLeftY=-OBJECT_H;
  - delayCnt=0, hitCnt=0;
  - LFSR=LFSR_SEED;
  - offsetX=0, offsetY=0, InsideRectangle=0, active=0.
REQ-032 SHALL, on reset mid-MOVING, have the object vanish within the same cycle the outputs are cleared.

Configuration
REQ-033 SHALL, with OIL_RANDOM_SPAWN_EN defined, use spawn X = LANE_MIN_X + (LFSR[15:0] mod LANE_SPAN), rounded down to a multiple of 2.
REQ-034 SHALL, without OIL_RANDOM_SPAWN_EN, omit the LFSR and cycle spawn X through LANE_MIN_X, +LANE_SPAN/4, +LANE_SPAN/2 and +3*LANE_SPAN/4, then repeat.

Verification
REQ-035 SHALL cover this scenario: reset, enable=1, 61 startOfFrame pulses -> active=1 and topLeftY=-32 after the 61st pulse.
REQ-036 SHALL cover this scenario: MOVING, speed=4, topLeftY=476, startOfFrame -> WAIT_SPAWN, active=0, InsideRectangle stays 0.
REQ-037 SHALL cover this scenario: topLeftX=200, topLeftY=100, pixel (199,100), (200,100), (263,131) and (264,131) -> InsideRectangle 0,1,1,0 one clk later, with offsets (0,0) and (63,31) on the inside pixels.
REQ-038 SHALL cover this scenario: topLeftY=-10, pixel (topLeftX+5,0) -> InsideRectangle=1, offsetY=10.
REQ-039 SHALL cover this scenario: collision and startOfFrame in the same clk in MOVING -> HIT, topLeftY unchanged, WAIT_SPAWN after 16 frames.
REQ-040 SHALL cover this scenario: enable=0 mid-HIT -> IDLE the next clk; reset pulse during MOVING -> all outputs 0 immediately.
